px_seq: RTL

- Main-loop state sequencer and strobe generator that sits directly upstream of the P-M microinstruction unit.
- Holds the one-hot control state (P0..P5, K1, K2, WX) and produces the STROB1/STROB2/GOT timing that P-M consumes.
- Samples P-M's transition requests (ep0..ep5, ek1, ek2, pp, stp0) at end of state to select the next state.
- Replaces the analog univibrator timing with clocked tick counters.

---
 rtl/px_seq.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/px_seq.sv
// Main-loop state sequencer for the P-M microinstruction unit: one-hot control
// state plus clocked STROB1/STROB2/GOT timing in place of univibrator delays.
module px_seq #(
  parameter int STROB_TICKS = 2,
  parameter int GAP_TICKS   = 1
) (
  input  logic __clk,
  input  logic __rst_,
  input  logic clo,
  input  logic stp0,
  input  logic ep0,
  input  logic ep1,
  input  logic ep2,
  input  logic ep3,
  input  logic ep4,
  input  logic ep5,
  input  logic ek1,
  input  logic ek2,
  input  logic pp,
  input  logic ekc_w,
  output logic p0,
  output logic p1,
  output logic p2,
  output logic p3,
  output logic p4,
  output logic p5,
  output logic k1,
  output logic k2,
  output logic wx,
  output logic strob1,
  output logic strob2,
  output logic got,
  output logic busy
);

  // state | meaning
  // P0    | main idle/fetch state, waits for stp0 before cycling
  // P1-P5 | main-loop states, P1/P3 use two strobes
  // K1/K2 | auxiliary states, K2 uses two strobes
  // WX    | instruction execution, no strobes until ekc_w
  typedef enum logic [8:0] {
    ST_P0 = 9'b000000001,
    ST_P1 = 9'b000000010,
    ST_P2 = 9'b000000100,
    ST_P3 = 9'b000001000,
    ST_P4 = 9'b000010000,
    ST_P5 = 9'b000100000,
    ST_K1 = 9'b001000000,
    ST_K2 = 9'b010000000,
    ST_WX = 9'b100000000
  } state_t;

  typedef enum logic [2:0] {
    PH_IDLE,
    PH_S1,
    PH_GAP,
    PH_S2,
    PH_GOT
  } phase_t;

  localparam logic [3:0] STROB_LOAD = 4'(STROB_TICKS - 1);
  localparam logic [3:0] GAP_LOAD   = 4'(GAP_TICKS - 1);

  state_t     state, state_n, pick;
  phase_t     phase, phase_n;
  logic [3:0] cnt, cnt_n;
  logic       two_strobe;

  assign two_strobe = (state == ST_P1) || (state == ST_P3) || (state == ST_K2);
  assign {wx, k2, k1, p5, p4, p3, p2, p1, p0} = state;

  always_comb begin
    pick = ST_P0;
    if (ep0)      pick = ST_P0;
    else if (ek2) pick = ST_K2;
    else if (ek1) pick = ST_K1;
    else if (ep1) pick = ST_P1;
    else if (ep2) pick = ST_P2;
    else if (ep3) pick = ST_P3;
    else if (ep4) pick = ST_P4;
    else if (ep5) pick = ST_P5;
    else if (pp)  pick = ST_WX;
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt;
    case (phase)
      PH_IDLE: begin
        if (state == ST_WX) begin
          if (ekc_w) state_n = ST_P0;
        end else if (state != ST_P0 || stp0) begin
          phase_n = PH_S1;
          cnt_n   = STROB_LOAD;
        end
      end
      PH_S1: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else if (!two_strobe) begin
          phase_n = PH_GOT;
        end else if (GAP_TICKS == 0) begin
          phase_n = PH_S2;
          cnt_n   = STROB_LOAD;
        end else begin
          phase_n = PH_GAP;
          cnt_n   = GAP_LOAD;
        end
      end
      PH_GAP: begin
        if (cnt != 4'd0) begin
          cnt_n = cnt - 4'd1;
        end else begin
          phase_n = PH_S2;
          cnt_n   = STROB_LOAD;
        end
      end
      PH_S2: begin
        if (cnt != 4'd0) cnt_n = cnt - 4'd1;
        else             phase_n = PH_GOT;
      end
      PH_GOT: begin
        // Decision uses the requests present in the GOT clock itself
        state_n = pick;
        if (pick == ST_WX || (pick == ST_P0 && !stp0)) begin
          phase_n = PH_IDLE;
          cnt_n   = 4'd0;
        end else begin
          phase_n = PH_S1;
          cnt_n   = STROB_LOAD;
        end
      end
      default: begin
        phase_n = PH_IDLE;
        cnt_n   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge __clk) begin
    if (!__rst_ || clo) begin
      state  <= ST_P0;
      phase  <= PH_IDLE;
      cnt    <= 4'd0;
      strob1 <= 1'b0;
      strob2 <= 1'b0;
      got    <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      phase  <= phase_n;
      cnt    <= cnt_n;
      strob1 <= (phase_n == PH_S1);
      strob2 <= (phase_n == PH_S2);
      got    <= (phase_n == PH_GOT);
      busy   <= (phase_n != PH_IDLE);
    end
  end

endmodule
